// File: rtl/cpu_reset_sequencer.sv
// Reset/run-enable sequencer for the pipelined core: synchronised reset release,
// programmable hold, staggered per-domain release, free-run / single-step gating.

module cpu_reset_sequencer_ch #(
    parameter int CNT_W  = 8,
    parameter int REL_AT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             rel_en,
    input  logic [CNT_W-1:0] cnt,
    output logic             rst_q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rst_q <= 1'b1;
        else if (set)
            rst_q <= 1'b1;
        else if (rel_en && cnt == CNT_W'(REL_AT))
            rst_q <= 1'b0;
    end
endmodule

module cpu_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_CH      = 3,
    parameter int STAGGER     = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_rst_req,
    input  logic              step_mode,
    input  logic              step_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              cpu_en,
    output logic              ready,
    output logic [1:0]        rst_cause
);
    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_REL  = CNT_W'(STAGGER * (NUM_CH - 1));

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   sync_ok;
    logic                   step_q;
    logic                   cpu_en_nxt;
    logic [1:0]             cause_nxt;
    logic                   rst_all;
    logic                   rel_en;

    // Release edge of the board reset only ever reaches the FSM through this chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sync_pipe <= '0;
        else
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], 1'b1};
    end

    assign sync_ok = sync_pipe[SYNC_STAGES-1];
    assign ready   = (state == RUN);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cpu_en_nxt = 1'b0;
        cause_nxt  = rst_cause;
        rst_all    = 1'b0;
        rel_en     = 1'b0;
        if (sw_rst_req && state != HOLD) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            rst_all   = 1'b1;
            cause_nxt = 2'b10;
        end else begin
            case (state)
                HOLD: begin
                    if (sync_ok) begin
                        if (cnt == HOLD_LAST) begin
                            state_nxt = RELEASE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                RELEASE: begin
                    rel_en  = 1'b1;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == LAST_REL)
                        state_nxt = RUN;
                end
                RUN: begin
                    // Single-step grants one enable cycle per rising edge of step_req.
                    cpu_en_nxt = step_mode ? (step_req & ~step_q) : 1'b1;
                end
                default: state_nxt = HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HOLD;
            cnt       <= '0;
            cpu_en    <= 1'b0;
            rst_cause <= 2'b01;
            step_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cpu_en    <= cpu_en_nxt;
            rst_cause <= cause_nxt;
            step_q    <= step_req;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cpu_reset_sequencer_ch #(
            .CNT_W (CNT_W),
            .REL_AT(STAGGER * i)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .set   (rst_all),
            .rel_en(rel_en),
            .cnt   (cnt),
            .rst_q (rst_out[i])
        );
    end
endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Scoreboard bench for cpu_reset_sequencer: default instance plus a minimal
// single-channel instance (NUM_CH=1, HOLD=1, STAGGER=1, SYNC_STAGES=3).

module tb_cpu_reset_sequencer;
    logic       clk;
    logic       reset;
    logic       sw_rst_req;
    logic       step_mode;
    logic       step_req;
    logic [2:0] rst_out;
    logic       cpu_en;
    logic       ready;
    logic [1:0] rst_cause;
    logic [0:0] rst_out2;
    logic       cpu_en2;
    logic       ready2;
    logic [1:0] rst_cause2;

    typedef struct {
        logic [2:0] rst;
        logic       rdy;
        logic       en;
        logic [1:0] cause;
        logic       r2;
        logic       rdy2;
        logic       en2;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    cpu_reset_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .sw_rst_req(sw_rst_req),
        .step_mode (step_mode),
        .step_req  (step_req),
        .rst_out   (rst_out),
        .cpu_en    (cpu_en),
        .ready     (ready),
        .rst_cause (rst_cause)
    );

    cpu_reset_sequencer #(
        .SYNC_STAGES(3),
        .HOLD_CYCLES(1),
        .NUM_CH     (1),
        .STAGGER    (1),
        .CNT_W      (8)
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .sw_rst_req(sw_rst_req),
        .step_mode (step_mode),
        .step_req  (step_req),
        .rst_out   (rst_out2),
        .cpu_en    (cpu_en2),
        .ready     (ready2),
        .rst_cause (rst_cause2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // k = edge index after hardware reset release; a software reset edge maps to k=2.
    function automatic exp_t exp_at(input int k, input logic [1:0] cause);
        exp_t e;
        e.rst   = (k < 19) ? 3'b111 : (k < 23) ? 3'b110 : (k < 27) ? 3'b100 : 3'b000;
        e.rdy   = (k >= 27);
        e.en    = (k >= 28);
        e.cause = cause;
        e.r2    = (k < 5);
        e.rdy2  = (k >= 5);
        e.en2   = (k >= 6);
        return e;
    endfunction

    task automatic check_out(input string tag, input bit c2);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_qempty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_rst"},   32'(rst_out),   32'(e.rst));
        chk({tag, "_rdy"},   32'(ready),     32'(e.rdy));
        chk({tag, "_en"},    32'(cpu_en),    32'(e.en));
        chk({tag, "_cause"}, 32'(rst_cause), 32'(e.cause));
        if (c2) begin
            chk({tag, "_rst2"}, 32'(rst_out2), 32'(e.r2));
            chk({tag, "_rdy2"}, 32'(ready2),   32'(e.rdy2));
            chk({tag, "_en2"},  32'(cpu_en2),  32'(e.en2));
        end
    endtask

    task automatic run_seq(input string tag, input int k0, input int k1,
                           input logic [1:0] cause, input bit c2);
        for (int k = k0; k <= k1; k++) begin
            exp_q.push_back(exp_at(k, cause));
            @(posedge clk);
            #1;
            check_out($sformatf("%s_k%0d", tag, k), c2);
        end
    endtask

    int sr[17] = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};

    initial begin
        exp_t e;
        int   prev;
        reset      = 1'b0;
        sw_rst_req = 1'b0;
        step_mode  = 1'b0;
        step_req   = 1'b0;

        // 1: power-on sequence
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(exp_at(0, 2'b01));
        check_out("por_rst", 1'b1);
        reset = 1'b1;
        run_seq("por", 1, 28, 2'b01, 1'b1);

        // 2: async reset mid-release, then a full repeat
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_seq("s2a", 1, 24, 2'b01, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(exp_at(0, 2'b01));
        check_out("async", 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_seq("s2b", 1, 28, 2'b01, 1'b1);

        // 3: one-cycle software reset from RUN
        sw_rst_req = 1'b1;
        run_seq("swr", 2, 2, 2'b10, 1'b0);
        sw_rst_req = 1'b0;
        run_seq("swr", 3, 28, 2'b10, 1'b0);

        // 4: single-step; held request and isolated pulses
        prev = 0;
        for (int i = 0; i < 17; i++) begin
            step_mode = 1'b1;
            step_req  = sr[i][0];
            e = exp_at(28, 2'b10);
            e.en = (sr[i] == 1 && prev == 0);
            prev = sr[i];
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            check_out($sformatf("step%0d", i), 1'b0);
        end
        step_mode = 1'b0;
        step_req  = 1'b0;
        run_seq("free", 28, 28, 2'b10, 1'b0);

        // 5: software reset held during HOLD is ignored
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(exp_at(0, 2'b01));
        check_out("s5_rst", 1'b0);
        reset      = 1'b1;
        sw_rst_req = 1'b1;
        run_seq("s5", 1, 10, 2'b01, 1'b0);
        sw_rst_req = 1'b0;
        run_seq("s5", 11, 28, 2'b01, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
